// File: rtl/morse_seq_pkg.sv
// Shared types and defaults for the Morse symbol sequencer.
// Optional loop mode is enabled with MORSE_SEQ_LOOP_EN.
package morse_seq_pkg;

    localparam int MORSE_W = 3;
    localparam int MORSE_N = 12;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } seq_state_e;

    function automatic logic [MORSE_W-1:0] entry_of(
        input logic [MORSE_N*MORSE_W-1:0] tbl,
        input int                         k
    );
        if (k < 1 || k > MORSE_N)
            return '0;
        return tbl[k*MORSE_W-1 -: MORSE_W];
    endfunction

endpackage

// File: rtl/morse_symbol_sequencer_mux.sv
// N+1:1 symbol selector; index 0 or out-of-range selects 0.
// Used by morse_symbol_sequencer (MORSE_SEQ_LOOP_EN has no effect here).
module mux_sel_param #(
    parameter int W    = 3,
    parameter int N    = 12,
    parameter int SELW = $clog2(N+1)
) (
    input  logic [N*W-1:0]  tbl,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    y
);

    always_comb begin
        y = '0;
        for (int k = 1; k <= N; k++) begin
            if (sel == SELW'(k))
                y = tbl[k*W-1 -: W];
        end
    end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Walks a snapshot of the symbol table and streams entries 1..length with valid/ready.
// Define MORSE_SEQ_LOOP_EN to add the repetir port and multi-pass looping.
module morse_symbol_sequencer
    import morse_seq_pkg::*;
#(
    parameter int W    = MORSE_W,
    parameter int N    = MORSE_N,
    parameter int SELW = $clog2(N+1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  entradas,
    input  logic            start,
    input  logic [SELW-1:0] length,
`ifdef MORSE_SEQ_LOOP_EN
    input  logic            repetir,
`endif
    output logic [W-1:0]    salida,
    output logic            salida_valid,
    input  logic            salida_ready,
    output logic            busy,
    output logic            done,
    output logic            err
);

    seq_state_e      state_q, state_d;
    logic [SELW-1:0] idx_q, idx_d;
    logic [SELW-1:0] len_q, len_d;
    logic [N*W-1:0]  snap_q, snap_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            len_ok;
    logic            xfer;
    logic [W-1:0]    sym;

    assign len_ok = (length != '0) && (length <= SELW'(N));
    assign xfer   = salida_valid & salida_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            snap_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = ST_RUN;
                        idx_d   = SELW'(1);
                        len_d   = length;
                        snap_d  = entradas;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (idx_q < len_q) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
`ifdef MORSE_SEQ_LOOP_EN
                        if (repetir) begin
                            idx_d = SELW'(1);
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                        end
`else
                        state_d = ST_IDLE;
                        idx_d   = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    mux_sel_param #(
        .W    (W),
        .N    (N),
        .SELW (SELW)
    ) u_mux (
        .tbl (snap_q),
        .sel (idx_q),
        .y   (sym)
    );

    // Outputs depend only on flops; idx is 0 in IDLE so salida falls to 0 there.
    assign salida_valid = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN);
    assign salida       = salida_valid ? sym : '0;
    assign done         = done_q;
    assign err          = err_q;

endmodule
